bcd_counter_ndigit: RTL
=======================

# bcd_counter_ndigit

Parametrised synchronous BCD counter with DIGITS cascaded decimal digits. It counts up or down under an enable, supports a synchronous parallel load, and wraps at a runtime-programmable BCD limit. It is the general replacement for the fixed one- and two-digit decade counters in the lab counter set. It drives display and sequencing logic that needs decimal counts with modulus other than a power of ten.

## Interface

- DIGITS, 2, number of BCD digits (1..8); count width is 4*DIGITS
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; sampled on rising clk
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i]
- limit  input  4*DIGITS  BCD terminal value; count range is 0..limit
- count  output  4*DIGITS  current BCD count, registered
- wrap  output  1  one-cycle registered pulse, high in the cycle count shows a wrapped value
- load_err  output  1  one-cycle registered pulse, high after a load that contained a non-BCD digit

## Operation

- Priority per rising edge: reset > load > en > hold.
- reset: count = 0, wrap = 0, load_err = 0.
- load: each digit of load_val > 9 is replaced by 0, and the others load unchanged.
  - load_err = 1 if any digit was replaced.
  - wrap = 0.
  - en is ignored in that cycle.
- en=1, up=1:
  - if count >= limit (BCD magnitude compare), count becomes 0 and wrap = 1;
  - otherwise BCD increment: digit 9 becomes 0 and carries to the next digit.
- en=1, up=0:
  - if count == 0, count becomes limit with non-BCD digits of limit forced to 0, and wrap = 1;
  - otherwise BCD decrement: digit 0 becomes 9 and borrows from the next digit.
- en=0, no load: count holds; wrap = 0; load_err = 0.
- limit = 0: up and down both hold count at 0 with wrap = 1 on every enabled cycle.
- limit is sampled every cycle. Changing it mid-count takes effect on the next enabled edge; a count above the new limit wraps to 0 on the next up step.
- Digit values 10..15 never appear on count.

## Timing

- All outputs are registered; none depend combinationally on inputs.
- Latency from input to count is one clock.
- wrap and load_err are single-cycle pulses, aligned with the count value they describe.
- Back-to-back enabled cycles step count every cycle, with no bubble at digit carries or at wrap.
- A reset asserted mid-count clears everything on that edge. The first step after release occurs on the first edge with en=1 and reset=0.
- load and en in the same cycle: the load wins, and counting resumes from the loaded value on the next edge.

## Structure

- Shared package bcd_pkg holds:
  - BCD_W = 4, BCD_MAX = 4'd9;
  - a function bcd_valid(digit);
  - a function bcd_ge(a, b), the digit-serial MSB-first magnitude compare, parametrised by DIGITS.
- Sub-module bcd_digit, instantiated DIGITS times via generate:
  - inputs: step_in, up, clear, load;
  - outputs: next digit and step_out (carry or borrow to the next digit).
- The top level holds:
  - the count register;
  - the terminal detect (count >= limit, count == 0);
  - the wrap and load_err registers;
  - the load sanitising logic.

## Test plan

All scenarios use DIGITS=2.

1. Reset, limit=8'h99, up=1, en=1 for 105 cycles: count steps 00..99 then 00..04; wrap is high only in the cycle count = 00 after 99.
2. limit=8'h59, up=0, en=1 from reset: count goes 00 → 59 with wrap=1, then steps 58..00 and wraps to 59 again. Covers units borrow from 50 to 49.
3. load=1 with load_val=8'h3A: count = 30, load_err=1 for one cycle; the next enabled up step gives 31.
4. Count at 45 with limit=8'h99, then limit changes to 8'h20 and up steps: count goes 45 → 00 with wrap=1, then 01.
5. en toggled 1,0,0,1 from 17: count goes 18, 18, 18, 19 and wrap stays 0. Also load with en=1 in the same cycle: count equals load_val and no step occurs.
6. reset asserted while counting at 73 with load=1 in the same cycle: count = 00, wrap=0, load_err=0 on that edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the N-digit decade counter.
// Digit validity and the MSB-first magnitude compare live here.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int BCD_MAX_DIGITS = 8;

    function automatic logic bcd_valid(input logic [3:0] digit);
        return digit <= BCD_MAX;
    endfunction

    // Operands are zero-extended to 8 digits; only the low digits count.
    function automatic logic bcd_ge(
        input logic [4*BCD_MAX_DIGITS-1:0] a,
        input logic [4*BCD_MAX_DIGITS-1:0] b,
        input int digits
    );
        logic decided;
        logic result;
        decided = 1'b0;
        result = 1'b1;
        for (int i = BCD_MAX_DIGITS - 1; i >= 0; i--) begin
            if (i < digits && !decided) begin
                if (a[4*i+:4] != b[4*i+:4]) begin
                    decided = 1'b1;
                    result = a[4*i+:4] > b[4*i+:4];
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade stage: computes the next digit value and the carry/borrow
// passed to the next more significant digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    input  logic [3:0] ld_digit,
    input  logic       step_in,
    input  logic       up,
    input  logic       clear,
    input  logic       load,
    output logic [3:0] next,
    output logic       step_out
);

    always_comb begin
        next = d;
        step_out = 1'b0;
        if (clear) begin
            next = 4'd0;
        end else if (load) begin
            next = ld_digit;
        end else if (step_in) begin
            if (up) begin
                if (d >= BCD_MAX) begin
                    next = 4'd0;
                    step_out = 1'b1;
                end else begin
                    next = d + 4'd1;
                end
            end else begin
                if (d == 4'd0) begin
                    next = BCD_MAX;
                    step_out = 1'b1;
                end else begin
                    next = d - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_ndigit.sv
// Cascaded up/down BCD counter with parallel load and a runtime BCD
// limit; count range is 0..limit and wraps in both directions.
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic [4*DIGITS-1:0] limit,
    output logic [4*DIGITS-1:0] count,
    output logic                wrap,
    output logic                load_err
);

    localparam int W = BCD_W * DIGITS;
    localparam int PW = BCD_W * BCD_MAX_DIGITS;

    logic [W-1:0]    san_load;
    logic [W-1:0]    san_limit;
    logic [W-1:0]    ld_word;
    logic [W-1:0]    count_nxt;
    logic [DIGITS-1:0] bad_digit;
    logic [DIGITS:0] step;
    logic            at_top;
    logic            at_zero;
    logic            wrap_up;
    logic            wrap_dn;
    logic            wrap_evt;
    logic            clear;
    logic            dload;
    logic            unused_carry;

    for (genvar i = 0; i < DIGITS; i++) begin : g_san
        assign bad_digit[i] = !bcd_valid(load_val[4*i+:4]);
        assign san_load[4*i+:4] =
            bad_digit[i] ? 4'd0 : load_val[4*i+:4];
        assign san_limit[4*i+:4] =
            bcd_valid(limit[4*i+:4]) ? limit[4*i+:4] : 4'd0;
    end

    assign at_top = bcd_ge(PW'(count), PW'(limit), DIGITS);
    assign at_zero = (count == '0);

    assign wrap_up = en && up && at_top;
    assign wrap_dn = en && !up && at_zero;
    assign wrap_evt = !load && (wrap_up || wrap_dn);

    // Wrap to zero is a clear; wrap downward reloads the sanitised limit.
    assign clear = reset || (!load && wrap_up);
    assign dload = load || wrap_dn;
    assign ld_word = load ? san_load : san_limit;

    assign step[0] = en && !load && !reset && !wrap_up && !wrap_dn;
    assign unused_carry = step[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit u_digit (
            .d        (count[4*i+:4]),
            .ld_digit (ld_word[4*i+:4]),
            .step_in  (step[i]),
            .up       (up),
            .clear    (clear),
            .load     (dload),
            .next     (count_nxt[4*i+:4]),
            .step_out (step[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap <= wrap_evt;
            load_err <= load && (|bad_digit);
        end
    end

endmodule
